// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and helpers for the AXI-stream round-robin arbiter.
package axis_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// Minimal AXI-stream channel: data, valid, ready with producer/consumer views.
interface axis_if #(
    parameter type data_t = logic [31:0]
) ();
    data_t data;
    logic  valid;
    logic  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/axis_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after start, wrapping.
module rr_pick
    import axis_arb_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int IW   = idx_width(N_IN)
) (
    input  logic [N_IN-1:0] req,
    input  logic [IW-1:0]   start,
    output logic            found,
    output logic [IW-1:0]   idx
);

    logic [IW:0] cand;

    // Walk the search order backwards so the earliest candidate is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            cand = {1'b0, start} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_IN)) begin
                cand = cand - (IW+1)'(N_IN);
            end
            if (req[cand[IW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter sharing one AXI-stream sink among N_IN sources,
// with bursts capped at MAX_BURST beats and bubble-free grant hand-over.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N_IN      = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    axis_if.slave                        in [N_IN],
    axis_if.master                       out,
    output logic [idx_width(N_IN)-1:0]   grant,
    output logic                         busy
);

    localparam int IW = idx_width(N_IN);
    localparam int BW = idx_width(MAX_BURST + 1);
    localparam int DW = $bits(out.data);

    if (N_IN < 2) begin : g_bad_n_in
        $error("axis_rr_arbiter: N_IN must be at least 2");
    end
    if (MAX_BURST < 1) begin : g_bad_max_burst
        $error("axis_rr_arbiter: MAX_BURST must be at least 1");
    end

    arb_state_e      state_reg;
    logic [IW-1:0]   grant_reg;
    logic [IW-1:0]   rr_ptr_reg;
    logic [BW-1:0]   beats_reg;

    logic [N_IN-1:0] valid_vec;
    logic [DW-1:0]   data_arr [N_IN];

    logic [IW-1:0]   next_ptr;
    logic            found_idle;
    logic [IW-1:0]   idx_idle;
    logic            found_rel;
    logic [IW-1:0]   idx_rel;

    logic            granted;
    logic            owner_valid;
    logic            xfer;
    logic            at_limit;
    logic            release_grant;

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_src
        if ($bits(in[gi].data) != DW) begin : g_bad_type
            $error("axis_rr_arbiter: source data type differs from sink data type");
        end
        assign valid_vec[gi] = in[gi].valid;
        assign data_arr[gi]  = in[gi].data;
        assign in[gi].ready  = granted && (grant_reg == IW'(gi)) && out.ready;
    end

    assign granted     = (state_reg == GRANT);
    assign owner_valid = valid_vec[grant_reg];

    assign out.valid = granted && owner_valid;
    assign out.data  = data_arr[grant_reg];

    assign grant = grant_reg;
    assign busy  = granted;

    assign next_ptr = (grant_reg == IW'(N_IN - 1)) ? '0 : grant_reg + IW'(1);

    assign xfer          = out.valid && out.ready;
    assign at_limit      = (beats_reg == BW'(MAX_BURST - 1));
    // An idle owner releases too; AXIS sources only drop valid after a handshake.
    assign release_grant = (xfer && at_limit) || !owner_valid;

    rr_pick #(.N_IN(N_IN), .IW(IW)) u_pick_idle (
        .req   (valid_vec),
        .start (rr_ptr_reg),
        .found (found_idle),
        .idx   (idx_idle)
    );

    // The releasing owner is searched last, giving it the lowest priority.
    rr_pick #(.N_IN(N_IN), .IW(IW)) u_pick_rel (
        .req   (valid_vec),
        .start (next_ptr),
        .found (found_rel),
        .idx   (idx_rel)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
            beats_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (found_idle) begin
                        state_reg <= GRANT;
                        grant_reg <= idx_idle;
                        beats_reg <= '0;
                    end
                end
                GRANT: begin
                    if (release_grant) begin
                        rr_ptr_reg <= next_ptr;
                        beats_reg  <= '0;
                        if (found_rel) begin
                            grant_reg <= idx_rel;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (xfer) begin
                        beats_reg <= beats_reg + BW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Randomized bench for axis_rr_arbiter against a grant/burst reference model.
module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int MB = 8;

    typedef logic [15:0] word_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axis_if #(.data_t(word_t)) src [N] ();
    axis_if #(.data_t(word_t)) snk ();

    logic [1:0]  grant;
    logic        busy;
    logic        sv      [N];
    int unsigned seq     [N];
    logic        src_rdy [N];
    logic        sink_ready;

    int on_pct   [N];
    int keep_pct [N];
    int rdy_pct;

    for (genvar gi = 0; gi < N; gi++) begin : g_src
        assign src[gi].valid = sv[gi];
        assign src[gi].data  = {4'(gi), seq[gi][11:0]};
        assign src_rdy[gi]   = src[gi].ready;
    end
    assign snk.ready = sink_ready;

    axis_rr_arbiter #(.N_IN(N), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (src),
        .out   (snk),
        .grant (grant),
        .busy  (busy)
    );

    // Reference model: current owner (-1 = nobody), beats left in its burst,
    // and the position the next search starts from.
    int m_owner;
    int m_left;
    int m_ptr;
    bit hs [N];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_valid(input int from);
        for (int k = 0; k < N; k++) begin
            if (sv[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_left  = MB;
        m_ptr   = 0;
    endtask

    task automatic set_all(input int on, input int keep);
        for (int i = 0; i < N; i++) begin
            on_pct[i]   = on;
            keep_pct[i] = keep;
        end
    endtask

    // Outputs are checked at the falling edge, then the model and sources advance.
    task automatic step();
        bit exp_busy;
        bit exp_valid;
        bit fire;
        word_t exp_data;
        @(negedge clk);
        exp_busy  = (m_owner >= 0);
        exp_valid = exp_busy && sv[m_owner];
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("out_valid", 32'(snk.valid), 32'(exp_valid));
        if (exp_busy) chk("grant", 32'(grant), 32'(m_owner));
        if (exp_valid) begin
            exp_data = {4'(m_owner), seq[m_owner][11:0]};
            chk("out_data", 32'(snk.data), 32'(exp_data));
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("ready%0d", i), 32'(src_rdy[i]), 32'((m_owner == i) && sink_ready));
            hs[i] = (m_owner == i) && sv[i] && sink_ready && rst;
            if (hs[i]) $display("beat src=%0d seq=%0d t=%0t", i, seq[i], $time);
        end
        if (rst) begin
            if (m_owner < 0) begin
                m_owner = first_valid(m_ptr);
                m_left  = MB;
            end else begin
                fire = sv[m_owner] && sink_ready;
                if (fire) m_left--;
                if (!sv[m_owner] || m_left == 0) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = first_valid(m_ptr);
                    m_left  = MB;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                seq[i]++;
                sv[i] = ($urandom_range(99) < 32'(keep_pct[i]));
            end else if (!sv[i]) begin
                sv[i] = ($urandom_range(99) < 32'(on_pct[i]));
            end
        end
        sink_ready = ($urandom_range(99) < 32'(rdy_pct));
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) step();
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < N; i++) begin
            sv[i]  = 1'b1;
            seq[i] = 0;
        end
        sink_ready = 1'b1;
        rdy_pct    = 100;
        set_all(100, 100);

        // Held in reset with every source valid: nothing may be granted.
        run(4);
        rst = 1'b1;

        // Sources 1 and 3 drain; 0 and 2 then alternate in full bursts.
        on_pct[1] = 0; keep_pct[1] = 0;
        on_pct[3] = 0; keep_pct[3] = 0;
        run(80);

        // Mixed random traffic with moderate and then heavy backpressure.
        set_all(40, 70);
        rdy_pct = 75;
        run(500);
        rdy_pct = 25;
        run(300);

        // Sole requester 3, then source 0 joins after the wrap.
        set_all(0, 0);
        rdy_pct = 100;
        run(20);
        on_pct[3] = 100; keep_pct[3] = 100;
        run(30);
        on_pct[0] = 100; keep_pct[0] = 100;
        run(40);

        // Asynchronous reset between edges in the middle of a burst.
        set_all(100, 100);
        run(12);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(snk.valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < N; i++) chk($sformatf("arst_ready%0d", i), 32'(src_rdy[i]), 32'd0);
        model_reset();
        run(3);
        rst = 1'b1;
        run(40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
